m_ifetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the ID stage of the 5-stage pipeline.
- Drives a synchronous instruction memory (word address in, data valid one cycle after the address is sampled) and buffers the returned words with their PCs in a small FIFO.
- Presents the oldest word to ID through a valid/ready handshake, so decode stalls no longer lose fetched instructions.
- Taken-branch redirects from ID flush all buffered and in-flight fetches.

---
 rtl/m_ifetch_queue.sv | 131 +++++++++++++
 tb/tb_m_ifetch_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ifetch_queue.sv
// Purpose: instruction-fetch front end; issues word fetches to a synchronous imem and queues {ir, pc} for ID.
// Latency: 2 edges from issue to FIFO head; head outputs come straight from registered FIFO state.
// Backpressure: valid/ready toward ID; issue is throttled by a credit of occupancy plus in-flight fetches.
//
// Ports:
//   w_clk, w_rst             clock (posedge) and async active-low reset
//   w_redirect, w_tpc        taken branch from ID: flush everything, refetch from w_tpc
//   w_halt                   stop issuing new fetches while high
//   r_imem_req, r_imem_addr  registered fetch request / word address to imem
//   w_imem_data              imem read data, valid the cycle after the address is sampled
//   w_valid, w_ready         head handshake toward ID
//   w_ir, w_pc, w_pc4        head instruction, its PC and PC+4
//   r_count                  FIFO occupancy 0..DEPTH
module m_ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ADDR_W   = 12
) (
    input  logic                      w_clk,
    input  logic                      w_rst,
    input  logic                      w_redirect,
    input  logic [31:0]               w_tpc,
    input  logic                      w_halt,
    output logic                      r_imem_req,
    output logic [ADDR_W-1:0]         r_imem_addr,
    input  logic [31:0]               w_imem_data,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [31:0]               w_ir,
    output logic [31:0]               w_pc,
    output logic [31:0]               w_pc4,
    output logic [$clog2(DEPTH):0]    r_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [31:0]     r_fpc;
    logic [31:0]     r_req_pc;
    logic [31:0]     r_rsp_pc;
    logic            r_rsp_v;

    logic [31:0]     w_tpc_al;
    logic [CW:0]     w_credit;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    entry_t          w_head;

    // Redirect targets are word aligned; low two bits are dropped.
    assign w_tpc_al = w_tpc & ~32'h3;

    // Occupancy plus everything already issued must leave room, so a push can
    // never find the FIFO full. Pops in the same cycle are deliberately not credited.
    assign w_credit = {1'b0, r_count} + (CW+1)'(r_imem_req) + (CW+1)'(r_rsp_v);
    assign w_issue  = !w_halt && (w_credit < (CW+1)'(DEPTH));

    // Redirect kills the arriving response and any pop in the same edge.
    assign w_push = r_rsp_v && !w_redirect;
    assign w_pop  = w_valid && w_ready && !w_redirect;

    assign w_head  = r_mem[r_rptr];
    assign w_valid = (r_count != '0);
    assign w_ir    = w_head.ir;
    assign w_pc    = w_head.pc;
    assign w_pc4   = w_head.pc + 32'd4;

    // Fetch request / response pipeline and FIFO control.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_fpc       <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_req_pc    <= RESET_PC;
            r_rsp_v     <= 1'b0;
            r_rsp_pc    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else if (w_redirect) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_rsp_v  <= 1'b0;
            r_rsp_pc <= r_req_pc;
            if (!w_halt) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= w_tpc_al[ADDR_W+1:2];
                r_req_pc    <= w_tpc_al;
                r_fpc       <= w_tpc_al + 32'd4;
            end else begin
                r_imem_req <= 1'b0;
                r_fpc      <= w_tpc_al;
            end
        end else begin
            r_rsp_v  <= r_imem_req;
            r_rsp_pc <= r_req_pc;
            if (w_issue) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= r_fpc[ADDR_W+1:2];
                r_req_pc    <= r_fpc;
                r_fpc       <= r_fpc + 32'd4;
            end else begin
                r_imem_req <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge w_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{ir: w_imem_data, pc: r_rsp_pc};
        end
    end

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Purpose: directed self-checking bench for m_ifetch_queue with a synchronous imem model.
// Latency: checks sampled 1 ns after each posedge.
// Backpressure: w_ready driven per scenario to exercise stall, drain and redirect.
module tb_m_ifetch_queue;

    logic        w_clk;
    logic        w_rst;
    logic        w_redirect;
    logic [31:0] w_tpc;
    logic        w_halt;
    logic        r_imem_req;
    logic [11:0] r_imem_addr;
    logic [31:0] w_imem_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_ir;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [2:0]  r_count;

    int tests = 0;
    int fails = 0;

    m_ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .ADDR_W(12)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_redirect  (w_redirect),
        .w_tpc       (w_tpc),
        .w_halt      (w_halt),
        .r_imem_req  (r_imem_req),
        .r_imem_addr (r_imem_addr),
        .w_imem_data (w_imem_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_ir        (w_ir),
        .w_pc        (w_pc),
        .w_pc4       (w_pc4),
        .r_count     (r_count)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Synchronous imem: mem[i] = 0x1000_0000 + i
    always @(posedge w_clk) begin
        if (r_imem_req) w_imem_data <= 32'h1000_0000 + {20'd0, r_imem_addr};
    end

    // Advance one edge, sample 1 ns later, and check occupancy never exceeds DEPTH.
    task automatic tick();
        @(posedge w_clk);
        #1;
        tests++;
        if (r_count > 3'd4) begin
            fails++;
            $display("FAIL count_bound: r_count=%0d limit 4", r_count);
        end
    endtask

    task automatic do_reset(input logic rdy);
        w_rst      = 1'b0;
        w_redirect = 1'b0;
        w_tpc      = 32'h0;
        w_halt     = 1'b0;
        w_ready    = rdy;
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b1;
    endtask

    task automatic check_head(input string name, input logic [31:0] exp_pc);
        tests++;
        if (w_valid !== 1'b1 || w_pc !== exp_pc || w_ir !== (32'h1000_0000 + (exp_pc >> 2))
            || w_pc4 !== exp_pc + 32'd4) begin
            fails++;
            $display("FAIL %s: valid=%b pc=%h ir=%h pc4=%h exp pc=%h ir=%h", name, w_valid, w_pc,
                     w_ir, w_pc4, exp_pc, 32'h1000_0000 + (exp_pc >> 2));
        end
    endtask

    task automatic test_reset();
        w_rst = 1'b1; w_redirect = 1'b0; w_tpc = 32'h0; w_halt = 1'b0; w_ready = 1'b0;
        #2 w_rst = 1'b0;
        #1;
        tests++;
        if (w_valid !== 1'b0 || r_count !== 3'd0 || r_imem_req !== 1'b0 || r_imem_addr !== 12'd0) begin
            fails++;
            $display("FAIL reset: valid=%b count=%0d req=%b addr=%h exp 0/0/0/0",
                     w_valid, r_count, r_imem_req, r_imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        tick();
        tick();
        tests++;
        if (w_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_latency: valid=%b after 2 edges exp 0", w_valid);
        end
        tick();
        check_head("stream_first", 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_head("stream_seq", 32'(4 * k));
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick();
        tests++;
        if (r_imem_req !== 1'b1) begin
            fails++;
            $display("FAIL bp_req_e4: req=%b exp 1", r_imem_req);
        end
        tick();
        tests++;
        if (r_imem_req !== 1'b0 || r_count !== 3'd3) begin
            fails++;
            $display("FAIL bp_req_drop: req=%b count=%0d exp 0/3", r_imem_req, r_count);
        end
        tick();
        tick();
        tick();
        tests++;
        if (r_count !== 3'd4 || r_imem_req !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: count=%0d req=%b exp 4/0", r_count, r_imem_req);
        end
        check_head("bp_head", 32'h0);
        w_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_head("bp_drain", 32'(4 * k));
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick();
        tests++;
        if (r_count !== 3'd2) begin
            fails++;
            $display("FAIL redir_pre: count=%0d exp 2", r_count);
        end
        w_redirect = 1'b1;
        w_tpc      = 32'h0000_0043;
        tick();
        w_redirect = 1'b0;
        w_tpc      = 32'h0;
        w_ready    = 1'b1;
        tests++;
        if (w_valid !== 1'b0 || r_count !== 3'd0 || r_imem_addr !== 12'h010 || r_imem_req !== 1'b1) begin
            fails++;
            $display("FAIL redir_flush: valid=%b count=%0d addr=%h req=%b exp 0/0/010/1",
                     w_valid, r_count, r_imem_addr, r_imem_req);
        end
        tick();
        tests++;
        if (w_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_gap: valid=%b exp 0", w_valid);
        end
        tick();
        check_head("redir_first", 32'h40);
        tick();
        check_head("redir_next", 32'h44);
        tick();
        check_head("redir_next2", 32'h48);
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) tick();
        check_head("rp_pre", 32'h8);
        w_redirect = 1'b1;
        w_tpc      = 32'h0000_0100;
        tick();
        w_redirect = 1'b0;
        tests++;
        if (w_valid !== 1'b0 || r_count !== 3'd0 || r_imem_addr !== 12'h040) begin
            fails++;
            $display("FAIL rp_flush: valid=%b count=%0d addr=%h exp 0/0/040",
                     w_valid, r_count, r_imem_addr);
        end
        tick();
        tick();
        check_head("rp_first", 32'h100);
        tick();
        check_head("rp_next", 32'h104);
    endtask

    task automatic test_halt();
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) tick();
        check_head("halt_pre", 32'h8);
        w_halt = 1'b1;
        tick();
        tests++;
        if (r_imem_req !== 1'b0) begin
            fails++;
            $display("FAIL halt_req: req=%b exp 0", r_imem_req);
        end
        check_head("halt_inflight1", 32'hC);
        tick();
        check_head("halt_inflight2", 32'h10);
        tick();
        tick();
        tests++;
        if (w_valid !== 1'b0 || r_count !== 3'd0 || r_imem_req !== 1'b0) begin
            fails++;
            $display("FAIL halt_drained: valid=%b count=%0d req=%b exp 0/0/0",
                     w_valid, r_count, r_imem_req);
        end
        w_halt = 1'b0;
        tick();
        tests++;
        if (r_imem_req !== 1'b1 || r_imem_addr !== 12'd5) begin
            fails++;
            $display("FAIL halt_resume_req: req=%b addr=%h exp 1/005", r_imem_req, r_imem_addr);
        end
        tick();
        tick();
        check_head("halt_resume", 32'h14);
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        for (int k = 0; k < 5; k++) tick();
        tests++;
        if (r_count !== 3'd3) begin
            fails++;
            $display("FAIL areset_pre: count=%0d exp 3", r_count);
        end
        #3 w_rst = 1'b0;
        #1;
        tests++;
        if (w_valid !== 1'b0 || r_count !== 3'd0 || r_imem_req !== 1'b0) begin
            fails++;
            $display("FAIL areset_now: valid=%b count=%0d req=%b exp 0/0/0",
                     w_valid, r_count, r_imem_req);
        end
        #2 w_rst = 1'b1;
        w_ready = 1'b1;
        tick();
        tick();
        tick();
        check_head("areset_restart", 32'h0);
        tick();
        check_head("areset_next", 32'h4);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
